// File: rtl/multi_byte_rx.sv
// UART 8N1 receiver that packs DATA_WIDTH/8 consecutive bytes into one word.
// Bit timing, byte framing, inter-byte timeout and word assembly share one FSM.
module multi_byte_rx #(
  parameter int DATA_WIDTH   = 32,
  parameter bit MSB_1st      = 1'b1,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            baud_set,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] multi_byte_data_out,
  output logic                  multi_byte_rx_done,
  output logic                  frame_err,
  output logic                  timeout_err,
  output logic                  uart_state
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [31:0] DIV_9600   = 32'(CLK_FREQ / 9600);
  localparam logic [31:0] DIV_19200  = 32'(CLK_FREQ / 19200);
  localparam logic [31:0] DIV_38400  = 32'(CLK_FREQ / 38400);
  localparam logic [31:0] DIV_57600  = 32'(CLK_FREQ / 57600);
  localparam logic [31:0] DIV_115200 = 32'(CLK_FREQ / 115200);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, WAIT_HIGH} state_t;

  state_t                  state, state_n;
  logic                    rx_meta, rx_s, rx_prev;
  logic [31:0]             div, div_n;
  logic [31:0]             cnt, cnt_n;
  logic [2:0]              bit_cnt, bit_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [7:0]              shreg, shreg_n;
  logic [DATA_WIDTH-1:0]   word, word_n;
  logic [DATA_WIDTH-1:0]   data_n, assembled;
  logic                    done_n, ferr_n, terr_n, ustate_n;
  logic                    fall, last_byte;
  logic [IDX_W-1:0]        slot;
  logic [31:0]             baud_div, half_m1, bit_end, gap_end;

  assign fall      = rx_prev & ~rx_s;
  assign last_byte = (idx == IDX_W'(NBYTES - 1));
  assign slot      = MSB_1st ? (IDX_W'(NBYTES - 1) - idx) : idx;
  assign half_m1   = (div >> 1) - 32'd1;
  assign bit_end   = div - 32'd1;
  assign gap_end   = 32'(TIMEOUT_BITS) * div - 32'd1;

  always_comb begin
    case (baud_set)
      3'd1:    baud_div = DIV_19200;
      3'd2:    baud_div = DIV_38400;
      3'd3:    baud_div = DIV_57600;
      3'd4:    baud_div = DIV_115200;
      default: baud_div = DIV_9600;
    endcase
  end

  // Word being built with the current byte dropped into its slot.
  always_comb begin
    assembled = word;
    assembled[int'(slot) * 8 +: 8] = shreg;
  end

  always_comb begin
    state_n  = state;
    div_n    = div;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    word_n   = word;
    data_n   = multi_byte_data_out;
    done_n   = 1'b0;
    ferr_n   = 1'b0;
    terr_n   = 1'b0;
    ustate_n = uart_state;
    case (state)
      IDLE: begin
        // Tracking baud_set only here freezes the rate for the whole word.
        div_n = baud_div;
        if (fall) begin
          state_n  = START;
          cnt_n    = 32'd0;
          ustate_n = 1'b1;
        end
      end
      START: begin
        if (cnt == half_m1) begin
          cnt_n = 32'd0;
          if (!rx_s) begin
            state_n = DATA;
            bit_n   = 3'd0;
          end else if (idx == '0) begin
            state_n  = IDLE;
            ustate_n = 1'b0;
          end else begin
            state_n = GAP;
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      DATA: begin
        if (cnt == bit_end) begin
          cnt_n   = 32'd0;
          shreg_n = {rx_s, shreg[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      STOP: begin
        if (cnt == bit_end) begin
          cnt_n = 32'd0;
          if (rx_s) begin
            if (last_byte) begin
              data_n   = assembled;
              done_n   = 1'b1;
              ustate_n = 1'b0;
              idx_n    = '0;
              state_n  = IDLE;
            end else begin
              word_n  = assembled;
              idx_n   = idx + 1'b1;
              state_n = GAP;
            end
          end else begin
            ferr_n   = 1'b1;
            idx_n    = '0;
            ustate_n = 1'b0;
            state_n  = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      GAP: begin
        if (fall) begin
          state_n = START;
          cnt_n   = 32'd0;
        end else if (cnt == gap_end) begin
          terr_n   = 1'b1;
          idx_n    = '0;
          ustate_n = 1'b0;
          cnt_n    = 32'd0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must rise before a new start edge counts.
        idx_n    = '0;
        ustate_n = 1'b0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta             <= 1'b1;
      rx_s                <= 1'b1;
      rx_prev             <= 1'b1;
      state               <= IDLE;
      div                 <= DIV_9600;
      cnt                 <= 32'd0;
      bit_cnt             <= 3'd0;
      idx                 <= '0;
      shreg               <= 8'd0;
      word                <= '0;
      multi_byte_data_out <= '0;
      multi_byte_rx_done  <= 1'b0;
      frame_err           <= 1'b0;
      timeout_err         <= 1'b0;
      uart_state          <= 1'b0;
    end else begin
      rx_meta             <= uart_rx;
      rx_s                <= rx_meta;
      rx_prev             <= rx_s;
      state               <= state_n;
      div                 <= div_n;
      cnt                 <= cnt_n;
      bit_cnt             <= bit_n;
      idx                 <= idx_n;
      shreg               <= shreg_n;
      word                <= word_n;
      multi_byte_data_out <= data_n;
      multi_byte_rx_done  <= done_n;
      frame_err           <= ferr_n;
      timeout_err         <= terr_n;
      uart_state          <= ustate_n;
    end
  end

endmodule
